// File: rtl/df_pkg.sv
// Shared definitions for the dataflow network scheduler and its per-actor controllers.
// Holds the network FSM state encoding and the df_controller return codes.
package df_pkg;

  // Network-level scheduler states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // df_controller return codes reported through the actor ap_return
  localparam logic [31:0] RETURN_IDLE          = 32'd0;
  localparam logic [31:0] RETURN_WAIT_INPUT    = 32'd1;
  localparam logic [31:0] RETURN_WAIT_OUTPUT   = 32'd2;
  localparam logic [31:0] RETURN_WAIT_GUARD    = 32'd3;
  localparam logic [31:0] RETURN_NOT_EXECUTED  = 32'd4;
  localparam logic [31:0] RETURN_EXECUTED      = 32'd5;

endpackage

// File: rtl/df_actor_busy_tracker.sv
// Busy flag for a single actor: set by its start, cleared by its done.
// Ports: ap_clk/ap_rst clock and async active-high reset; start, done from the
// controller and actor core; busy registered flag.
module df_actor_busy_tracker (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic start,
  input  logic done,
  output logic busy
);

  // Start wins over done: a same-cycle done+start is a back-to-back invocation
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) busy <= 1'b0;
    else        busy <= start | (busy & ~done);
  end

endmodule

// File: rtl/df_network_quiescence_monitor.sv
// Network-level scheduler for a set of df_controller/actor pairs.
// Broadcasts a level start to all controllers, tracks actor busy state and
// firings, detects quiescence and completes the ap_ctrl_hs handshake.
// Ports:
//   ap_clk, ap_rst                 clock, async active-high reset
//   ap_start/ap_done/ap_idle/ap_ready  host handshake
//   net_start                      level start broadcast to every controller
//   actor_start/actor_done         per-actor invocation start and completion
//   actor_fired                    per-actor "executed" completion pulse
//   fifo_not_empty                 per-actor input data available
//   others_executing               bit i = any actor other than i is busy
module df_network_quiescence_monitor
  import df_pkg::*;
#(
  parameter int unsigned NUM_ACTORS     = 4,
  parameter int unsigned QUIESCE_CYCLES = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  net_start,
  input  logic [NUM_ACTORS-1:0] actor_start,
  input  logic [NUM_ACTORS-1:0] actor_done,
  input  logic [NUM_ACTORS-1:0] actor_fired,
  input  logic [NUM_ACTORS-1:0] fifo_not_empty,
  output logic [NUM_ACTORS-1:0] others_executing
);

  localparam int unsigned      QCNT_W   = $clog2(QUIESCE_CYCLES + 1);
  localparam logic [QCNT_W-1:0] QCNT_MAX = QCNT_W'(QUIESCE_CYCLES);

  state_t              state_q, state_d;
  logic [NUM_ACTORS-1:0] busy;
  logic [QCNT_W-1:0]   qcnt_q, qcnt_d;
  logic                fired_q, fired_d;
  logic                act_c;

  // One busy flop per actor
  for (genvar i = 0; i < NUM_ACTORS; i++) begin : g_busy
    df_actor_busy_tracker u_trk (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .start  (actor_start[i]),
      .done   (actor_done[i]),
      .busy   (busy[i])
    );
  end

  // Each controller sees whether any other actor is mid-invocation
  if (NUM_ACTORS == 1) begin : g_single
    assign others_executing = '0;
  end else begin : g_multi
    always_comb begin
      others_executing = '0;
      for (int i = 0; i < NUM_ACTORS; i++) begin
        others_executing[i] = |(busy & ~(NUM_ACTORS'(1) << i));
      end
    end
  end

  assign act_c = (|actor_fired) | (|fifo_not_empty);

  // Next state, quiescence count and drain-fire flag
  always_comb begin
    state_d = state_q;
    fired_d = fired_q;
    qcnt_d  = '0;
    // qcnt_d includes the current cycle, so reaching the max means this is
    // the last quiet cycle required
    if (state_q == RUN && !act_c) begin
      qcnt_d = (qcnt_q == QCNT_MAX) ? qcnt_q : qcnt_q + QCNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        fired_d = 1'b0;
        if (ap_start) state_d = RUN;
      end
      RUN: begin
        fired_d = 1'b0;
        if (qcnt_d == QCNT_MAX) state_d = DRAIN;
      end
      DRAIN: begin
        // New data or a firing during drain restarts the network; a firing
        // seen this cycle also blocks the DONE exit until it is acted on
        if ((|fifo_not_empty) || fired_q) begin
          state_d = RUN;
          fired_d = 1'b0;
        end else if (|actor_fired) begin
          fired_d = 1'b1;
        end else if (busy == '0) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered handshake outputs
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= IDLE;
      qcnt_q    <= '0;
      fired_q   <= 1'b0;
      ap_idle   <= 1'b1;
      ap_done   <= 1'b0;
      ap_ready  <= 1'b0;
      net_start <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      fired_q   <= fired_d;
      ap_idle   <= (state_d == IDLE);
      ap_done   <= (state_d == DONE);
      ap_ready  <= (state_d == DONE);
      net_start <= (state_d == RUN);
    end
  end

endmodule

// File: tb/tb_df_network_quiescence_monitor.sv
// Directed bench for df_network_quiescence_monitor (NUM_ACTORS=4, QUIESCE_CYCLES=8).
module tb_df_network_quiescence_monitor;

  logic       ap_clk = 1'b0;
  logic       ap_rst;
  logic       ap_start;
  logic       ap_done, ap_idle, ap_ready, net_start;
  logic [3:0] actor_start, actor_done, actor_fired, fifo_not_empty;
  logic [3:0] others_executing;

  int n_cmp = 0;
  int n_bad = 0;

  df_network_quiescence_monitor #(.NUM_ACTORS(4), .QUIESCE_CYCLES(8)) dut (
    .ap_clk           (ap_clk),
    .ap_rst           (ap_rst),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .ap_ready         (ap_ready),
    .net_start        (net_start),
    .actor_start      (actor_start),
    .actor_done       (actor_done),
    .actor_fired      (actor_fired),
    .fifo_not_empty   (fifo_not_empty),
    .others_executing (others_executing)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the ap_done pulse
  task automatic wait_done(input string tag, input int max_cycles);
    int k = 0;
    while (ap_done !== 1'b1 && k < max_cycles) begin
      tick();
      k++;
    end
    chk(tag, 32'(ap_done), 32'd1);
    tick();
  endtask

  logic [3:0] pat_fifo [2];
  logic [3:0] pat_fire [2];
  logic       seen_done;

  initial begin
    ap_rst = 1'b1; ap_start = 1'b0;
    actor_start = '0; actor_done = '0; actor_fired = '0; fifo_not_empty = '0;
    tick(); tick();
    chk("rst_idle",   32'(ap_idle),   32'd1);
    chk("rst_done",   32'(ap_done),   32'd0);
    chk("rst_ready",  32'(ap_ready),  32'd0);
    chk("rst_nstart", 32'(net_start), 32'd0);
    chk("rst_others", 32'(others_executing), 32'd0);
    ap_rst = 1'b0;
    tick();

    // 1: quiet run, minimum latency
    ap_start = 1'b1; tick(); ap_start = 1'b0;
    chk("t1_nstart_c1", 32'(net_start), 32'd1);
    chk("t1_idle_c1",   32'(ap_idle),   32'd0);
    repeat (7) tick();
    chk("t1_run_c8",    32'(net_start), 32'd1);
    tick();
    chk("t1_drain_c9",  32'(net_start), 32'd0);
    chk("t1_nodone_c9", 32'(ap_done),   32'd0);
    tick();
    chk("t1_done_c10",  32'(ap_done),   32'd1);
    chk("t1_ready_c10", 32'(ap_ready),  32'd1);
    tick();
    chk("t1_done_off",  32'(ap_done),   32'd0);
    chk("t1_idle_c11",  32'(ap_idle),   32'd1);

    // 1b: ap_start held through DONE is re-accepted only from IDLE
    ap_start = 1'b1; tick();
    repeat (8) tick();
    tick();
    chk("t1b_done",     32'(ap_done),   32'd1);
    chk("t1b_done_nst", 32'(net_start), 32'd0);
    tick();
    chk("t1b_idle",     32'(ap_idle),   32'd1);
    chk("t1b_idle_nst", 32'(net_start), 32'd0);
    tick();
    chk("t1b_rerun",    32'(net_start), 32'd1);
    ap_start = 1'b0;
    wait_done("t1b_finish", 30);

    // 2: others_executing and same-cycle start/done
    actor_start = 4'b0010; tick(); actor_start = '0;
    chk("t2_others",    32'(others_executing), 32'hD);
    actor_start = 4'b0010; actor_done = 4'b0010; tick();
    actor_start = '0; actor_done = '0;
    chk("t2_backtoback", 32'(others_executing), 32'hD);
    actor_done = 4'b0010; tick(); actor_done = '0;
    chk("t2_cleared",   32'(others_executing), 32'h0);

    // 3: firing at qcnt=7 restarts the full quiet window
    ap_start = 1'b1; tick(); ap_start = 1'b0;
    repeat (7) tick();
    actor_fired = 4'b0100; tick(); actor_fired = '0;
    chk("t3_still_run", 32'(net_start), 32'd1);
    repeat (7) tick();
    chk("t3_run_late",  32'(net_start), 32'd1);
    tick();
    chk("t3_drain",     32'(net_start), 32'd0);
    tick();
    chk("t3_done",      32'(ap_done),   32'd1);
    tick();

    // 4: busy actor in DRAIN finishes with a firing -> back to RUN
    ap_start = 1'b1; actor_start = 4'b0001; tick();
    ap_start = 1'b0; actor_start = '0;
    repeat (8) tick();
    chk("t4_drain",     32'(net_start), 32'd0);
    tick();
    chk("t4_wait_busy", 32'(ap_done),   32'd0);
    actor_done = 4'b0001; actor_fired = 4'b0001; tick();
    actor_done = '0; actor_fired = '0;
    chk("t4_no_done_a", 32'(ap_done),   32'd0);
    tick();
    chk("t4_rerun",     32'(net_start), 32'd1);
    chk("t4_no_done_b", 32'(ap_done),   32'd0);
    wait_done("t4_finish", 30);

    // 5: data in DRAIN (alone, or with a firing) returns to RUN
    pat_fifo[0] = 4'b1000; pat_fire[0] = 4'b0000;
    pat_fifo[1] = 4'b0001; pat_fire[1] = 4'b0001;
    for (int p = 0; p < 2; p++) begin
      ap_start = 1'b1; tick(); ap_start = 1'b0;
      repeat (8) tick();
      chk("t5_drain",   32'(net_start), 32'd0);
      fifo_not_empty = pat_fifo[p]; actor_fired = pat_fire[p]; tick();
      fifo_not_empty = '0; actor_fired = '0;
      chk("t5_rerun",   32'(net_start), 32'd1);
      chk("t5_no_done", 32'(ap_done),   32'd0);
      wait_done("t5_finish", 30);
    end

    // 6: asynchronous reset mid-run
    ap_start = 1'b1; actor_start = 4'b1111; tick();
    ap_start = 1'b0; actor_start = '0;
    repeat (3) tick();
    chk("t6_others_all", 32'(others_executing), 32'hF);
    chk("t6_running",    32'(net_start), 32'd1);
    #2 ap_rst = 1'b1;
    #1;
    chk("t6_rst_nstart", 32'(net_start), 32'd0);
    chk("t6_rst_idle",   32'(ap_idle),   32'd1);
    chk("t6_rst_others", 32'(others_executing), 32'h0);
    ap_rst = 1'b0;
    seen_done = ap_done;
    for (int k = 0; k < 12; k++) begin
      tick();
      seen_done = seen_done | ap_done;
    end
    chk("t6_no_done",    32'(seen_done), 32'd0);
    chk("t6_idle_after", 32'(ap_idle),   32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
